// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer for the 8-bit RISC core: fetch, decode,
// ALU/register-file control, program counter, status flags and halt.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_valid,
    input  logic [7:0] imem_data,
    output logic [2:0] alu_ctrl,
    output logic       alu_flag,
    input  logic [7:0] alu_out,
    input  logic       alu_overflow,
    output logic [1:0] rf_raddr1,
    output logic [1:0] rf_raddr2,
    output logic [1:0] rf_waddr,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic [7:0] imm,
    output logic       ovf_flag,
    output logic       zero_flag,
    output logic       halted,
    output logic       illegal
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_FETCH_IMM = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    localparam logic [2:0] OP_LOGIC = 3'b000;
    localparam logic [2:0] OP_LI    = 3'b001;
    localparam logic [2:0] OP_BZ    = 3'b010;
    localparam logic [2:0] OP_ARITH = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ILL_A = 3'b101;
    localparam logic [2:0] OP_ILL_B = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] imm_q;
    logic       ovf_q;
    logic       zero_q;
    logic       run;
    logic [2:0] opcode;
    logic       fetching;
    logic       accept;
    logic       imm_accept;
    logic       in_exec;
    logic       li_write;

    assign opcode = ir[7:5];

    // run holds the request low until the first edge after reset release
    assign fetching   = run && ((state == S_FETCH) || (state == S_FETCH_IMM));
    assign accept     = fetching && imem_valid;
    assign imm_accept = accept && (state == S_FETCH_IMM);
    assign in_exec    = (state == S_EXEC);
    assign li_write   = imm_accept && (opcode == OP_LI);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (accept) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOGIC, OP_ARITH, OP_SHIFT: state_nxt = S_EXEC;
                    OP_LI, OP_BZ:                 state_nxt = S_FETCH_IMM;
                    OP_HALT:                      state_nxt = S_HALT;
                    default:                      state_nxt = S_FETCH;
                endcase
            end
            S_FETCH_IMM: begin
                if (accept) state_nxt = S_FETCH;
            end
            S_EXEC:  state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            imm_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            run    <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (accept && (state == S_FETCH)) begin
                ir <= imem_data;
                pc <= pc + 8'd1;
            end
            if (imm_accept) begin
                imm_q <= imem_data;
                // taken branch replaces the sequential increment
                if ((opcode == OP_BZ) && zero_q) pc <= imem_data;
                else                             pc <= pc + 8'd1;
            end
            if (in_exec) begin
                zero_q <= (alu_out == 8'h00);
                ovf_q  <= (opcode == OP_ARITH) && alu_overflow;
            end
        end
    end

    assign imem_req  = fetching;
    assign imem_addr = pc;

    assign alu_ctrl  = in_exec ? opcode : 3'b000;
    assign alu_flag  = in_exec && ir[4];

    assign rf_raddr1 = ir[3:2];
    assign rf_raddr2 = ir[1:0];
    assign rf_waddr  = ir[3:2];
    assign rf_we     = in_exec || li_write;
    assign rf_wsel   = li_write;

    // the LI write uses the byte being captured this cycle
    assign imm       = imm_accept ? imem_data : imm_q;

    assign ovf_flag  = ovf_q;
    assign zero_flag = zero_q;
    assign halted    = (state == S_HALT);
    assign illegal   = (state == S_DECODE) && ((opcode == OP_ILL_A) || (opcode == OP_ILL_B));

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a wait-state memory model feeds programs,
// expected fetch addresses and register writes are queued and checked on output.
module tb_control_unit;

    localparam logic [7:0] PC0 = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'hE0;
    logic [2:0] alu_ctrl;
    logic       alu_flag;
    logic [7:0] alu_out;
    logic       alu_overflow;
    logic [1:0] rf_raddr1;
    logic [1:0] rf_raddr2;
    logic [1:0] rf_waddr;
    logic       rf_we;
    logic       rf_wsel;
    logic [7:0] imm;
    logic       ovf_flag;
    logic       zero_flag;
    logic       halted;
    logic       illegal;

    control_unit #(.RESET_PC(PC0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_ctrl(alu_ctrl), .alu_flag(alu_flag),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .imm(imm),
        .ovf_flag(ovf_flag), .zero_flag(zero_flag),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [31:0] fetch_q [$];
    logic [31:0] wr_q [$];
    logic [31:0] exp_a;
    logic [31:0] exp_w;
    logic [7:0]  hold_addr;
    int unsigned mem_wait = 0;
    int unsigned wait_cnt = 0;
    int unsigned hold = 0;
    int unsigned cyc = 0;
    int unsigned first_we_cyc = 0;
    int unsigned ill_cnt = 0;
    int unsigned ill_cyc = 0;
    int unsigned halt_req_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_rec(input logic [1:0] rd, input logic [1:0] rs2,
                                           input logic wsel, input logic [2:0] ctrl,
                                           input logic flag, input logic [7:0] imm_v);
        return {13'b0, rd, rs2, rd, wsel, ctrl, flag, imm_v};
    endfunction

    // Memory responder drives on the falling edge, monitor samples 1 ns later.
    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_valid = 1'b1;
                imem_data  = mem[imem_addr];
            end else begin
                imem_valid = 1'b0;
                imem_data  = 8'hE0;
                wait_cnt++;
            end
        end else begin
            imem_valid = 1'b0;
            imem_data  = 8'hE0;
            wait_cnt   = 0;
        end
        #1;
        if (rst_n) begin
            cyc++;
            if (imem_req) begin
                if (hold == 0) hold_addr = imem_addr;
                hold++;
                if (imem_valid) begin
                    check("addr_stable", {24'b0, imem_addr}, {24'b0, hold_addr});
                    check("req_hold", hold, mem_wait + 1);
                    exp_a = (fetch_q.size() != 0) ? fetch_q.pop_front() : 32'hFFFF_FFFF;
                    check("fetch_addr", {24'b0, imem_addr}, exp_a);
                    hold     = 0;
                    wait_cnt = 0;
                end
            end else begin
                hold = 0;
            end
            if (rf_we) begin
                if (first_we_cyc == 0) first_we_cyc = cyc;
                exp_w = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
                check("rf_write", {13'b0, rf_raddr1, rf_raddr2, rf_waddr, rf_wsel, alu_ctrl,
                                   alu_flag, (rf_wsel ? imm : 8'h00)}, exp_w);
            end else begin
                check("alu_idle", {28'b0, alu_ctrl, alu_flag}, 32'h0);
            end
            if (illegal) begin
                ill_cnt++;
                ill_cyc = cyc;
            end
            if (halted && imem_req) halt_req_cnt++;
        end else begin
            cyc  = 0;
            hold = 0;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, {31'b0, imem_req, imem_addr}, {31'b0, 1'b0, PC0});
        check({tag, "_outs"}, {9'b0, alu_ctrl, alu_flag, rf_raddr1, rf_raddr2, rf_waddr,
                               rf_we, rf_wsel, imm, ovf_flag, zero_flag, halted, illegal}, 32'h0);
    endtask

    task automatic clear_tb();
        fetch_q.delete();
        wr_q.delete();
        first_we_cyc = 0;
        ill_cnt      = 0;
        ill_cyc      = 0;
        halt_req_cnt = 0;
        cyc          = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic restart(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        repeat (2) @(posedge clk);
        #2;
        clear_tb();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input string tag, input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_halt"}, {31'b0, halted}, 32'h1);
        check({tag, "_q_left"}, fetch_q.size() + wr_q.size(), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        alu_out      = 8'h00;
        alu_overflow = 1'b0;
        clear_tb();
        repeat (2) @(posedge clk);
        #2;
        check_reset("t1_rst");

        // LI r0,5 then SHL r3,r2; shift ignores carry-out for ovf
        mem[0] = 8'h22; mem[1] = 8'h05; mem[2] = 8'h9E; mem[3] = 8'hE0;
        foreach (mem[i]) if (i < 4) fetch_q.push_back(32'(i));
        wr_q.push_back(wr_rec(2'd0, 2'd2, 1'b1, 3'b000, 1'b0, 8'h05));
        wr_q.push_back(wr_rec(2'd3, 2'd2, 1'b0, 3'b100, 1'b1, 8'h00));
        alu_out = 8'h3C; alu_overflow = 1'b1;
        release_reset();
        run_until_halt("t1", 60);
        check("t1_we_cycle", first_we_cyc, 32'd3);
        check("t1_flags", {30'b0, zero_flag, ovf_flag}, 32'h0);

        // SUB r0,r1 sets both flags; BZ taken to 0x80; LI keeps flags
        restart("t2_rst");
        mem[0] = 8'h71; mem[1] = 8'h40; mem[2] = 8'h80;
        mem[8'h80] = 8'h2C; mem[8'h81] = 8'h5A; mem[8'h82] = 8'hE0;
        fetch_q = '{32'h00, 32'h01, 32'h02, 32'h80, 32'h81, 32'h82};
        wr_q.push_back(wr_rec(2'd0, 2'd1, 1'b0, 3'b011, 1'b1, 8'h00));
        wr_q.push_back(wr_rec(2'd3, 2'd0, 1'b1, 3'b000, 1'b0, 8'h5A));
        alu_out = 8'h00; alu_overflow = 1'b1;
        release_reset();
        run_until_halt("t2", 60);
        check("t2_flags", {30'b0, zero_flag, ovf_flag}, 32'h3);

        // NAND r1,r1 clears zero, ovf stays 0 for logic; BZ not taken
        restart("t3_rst");
        mem[0] = 8'h15; mem[1] = 8'h40; mem[2] = 8'h80; mem[3] = 8'hE0;
        fetch_q = '{32'h00, 32'h01, 32'h02, 32'h03};
        wr_q.push_back(wr_rec(2'd1, 2'd1, 1'b0, 3'b000, 1'b1, 8'h00));
        alu_out = 8'h01; alu_overflow = 1'b1;
        release_reset();
        run_until_halt("t3", 60);
        check("t3_flags", {30'b0, zero_flag, ovf_flag}, 32'h0);

        // 3 wait states; branch to 0xFF whose immediate is fetched from 0x00
        restart("t4_rst");
        mem_wait = 3;
        mem[0] = 8'h71; mem[1] = 8'h40; mem[2] = 8'hFF; mem[8'hFF] = 8'h40;
        fetch_q = '{32'h00, 32'h01, 32'h02, 32'hFF, 32'h00, 32'h71};
        wr_q.push_back(wr_rec(2'd0, 2'd1, 1'b0, 3'b011, 1'b1, 8'h00));
        alu_out = 8'h00; alu_overflow = 1'b0;
        release_reset();
        run_until_halt("t4", 200);
        check("t4_flags", {30'b0, zero_flag, ovf_flag}, 32'h2);

        // illegal opcode then HALT stays put
        restart("t5_rst");
        mem_wait = 0;
        mem[0] = 8'hA0; mem[1] = 8'hE0;
        fetch_q = '{32'h00, 32'h01};
        release_reset();
        run_until_halt("t5", 40);
        check("t5_ill_cnt", ill_cnt, 32'd1);
        check("t5_ill_cyc", ill_cyc, 32'd2);
        repeat (20) @(posedge clk);
        #2;
        check("t5_halt_req", halt_req_cnt, 32'd0);
        check("t5_still_halted", {31'b0, halted}, 32'h1);

        // reset while a fetch is waiting, then refetch from RESET_PC
        restart("t6_rst");
        mem_wait = 2;
        mem[0] = 8'h71;
        fetch_q.push_back(32'h00);
        release_reset();
        begin
            int n = 0;
            while (cyc < 3 && n < 20) begin
                @(negedge clk);
                #3;
                n++;
            end
        end
        check("t6_req_before_rst", {31'b0, imem_req}, 32'h1);
        restart("t6_mid_rst");
        mem_wait = 0;
        mem[0] = 8'h22; mem[1] = 8'h77; mem[2] = 8'hE0;
        fetch_q = '{32'h00, 32'h01, 32'h02};
        wr_q.push_back(wr_rec(2'd0, 2'd2, 1'b1, 3'b000, 1'b0, 8'h77));
        release_reset();
        run_until_halt("t6", 60);
        check("t6_we_cycle", first_we_cyc, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer for the 8-bit RISC core: fetches 8-bit instructions from instruction memory, decodes them, and drives the ALU's `ctrl`/`Flag` inputs and the register-file controls. It is the producer side of the ALU control interface. It also owns the program counter, the overflow and zero status flags, two-byte immediate and branch instructions, and the halt state.

## Interface
Parameters:
- `RESET_PC`, 8'h00, program counter value loaded on reset.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high until `imem_valid`.
- `imem_addr`  out  8  fetch address (= `pc` while `imem_req` is high).
- `imem_valid`  in  1  instruction byte valid this cycle; sampled only while `imem_req`=1.
- `imem_data`  in  8  instruction/immediate byte.
- `alu_ctrl`  out  3  ALU operation select (000 logic, 011 add/sub, 100 shift).
- `alu_flag`  out  1  ALU variant (logic: 1 NAND/0 NOR; arith: 1 SUB/0 ADD; shift: 1 SHL/0 SHR).
- `alu_out`  in  8  ALU result, for the zero flag.
- `alu_overflow`  in  1  ALU carry-out.
- `rf_raddr1`  out  2  source/destination register index (IR[3:2]).
- `rf_raddr2`  out  2  second source register index (IR[1:0]).
- `rf_waddr`  out  2  write register index (IR[3:2]).
- `rf_we`  out  1  register-file write enable, one cycle.
- `rf_wsel`  out  1  write-data select: 0 ALU result, 1 `imm`.
- `imm`  out  8  latched immediate byte.
- `ovf_flag`  out  1  overflow status.
- `zero_flag`  out  1  zero status.
- `halted`  out  1  high in HALT state.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Instruction format: IR[7:5] opcode, IR[4] variant bit, IR[3:2] rd/rs1, IR[1:0] rs2.
- Opcodes:
  - 000 LOGIC, 011 ARITH, 100 SHIFT: ALU ops, `rd <= rd op rs2`.
  - 001 LI: two-byte; `rd <= imm`.
  - 010 BZ: two-byte; `pc <= imm` if `zero_flag`=1.
  - 111 HALT.
  - 101, 110: illegal.
- States: FETCH, DECODE, FETCH_IMM, EXEC, HALT.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_valid`: IR <= `imem_data`, `pc` <= `pc`+1 (mod 256, 8'hFF wraps to 8'h00), go to DECODE.
- DECODE:
  - ALU opcodes go to EXEC.
  - LI/BZ go to FETCH_IMM.
  - HALT goes to HALT.
  - Illegal: pulse `illegal`, treat as NOP, go to FETCH.
- FETCH_IMM:
  - Same handshake as FETCH. On `imem_valid`: `imm` <= `imem_data`, `pc` <= `pc`+1.
  - LI: `rf_we`=1 and `rf_wsel`=1 in the same cycle as the capture, using the captured byte (`imm` is driven combinationally from `imem_data` during that cycle).
  - BZ: the branch target overrides the increment when `zero_flag`=1.
  - Next state FETCH.
- EXEC:
  - `alu_ctrl`=IR[7:5] and `alu_flag`=IR[4] for opcodes 000/011/100. `rf_we`=1, `rf_wsel`=0.
  - At the cycle end: `zero_flag` <= (`alu_out`==0).
  - `ovf_flag` <= `alu_overflow` for ARITH, 0 for LOGIC/SHIFT.
  - Next state FETCH.
- HALT: absorbing; only `rst_n` exits.
- Outside EXEC: `alu_ctrl`=000, `alu_flag`=0. `rf_we`=0 except in the cases above.
- LI and BZ do not modify the flags.

## Timing
- Reset (async assert, sync to state on first edge after deassert):
  - state FETCH, `pc`=`RESET_PC`, IR=0, `imm`=0, flags 0.
  - All outputs 0 except `imem_addr`=`RESET_PC`.
  - `imem_req` goes high in the first cycle after deassert.
- Reset asserted mid-handshake: `imem_req` drops immediately; a pending `imem_valid` is ignored.
- Memory latency is arbitrary (≥0 wait cycles, `imem_valid` may arrive in the first request cycle). `imem_req` and `imem_addr` are stable until the accepting edge.
- Cycles per instruction with zero-wait memory:
  - ALU ops: 3 (FETCH, DECODE, EXEC).
  - LI/BZ: 3 (FETCH, DECODE, FETCH_IMM).
  - Illegal: 2.
- The branch decision uses the flag value at the FETCH_IMM accepting edge.
- `illegal` is asserted for exactly the DECODE cycle.

## Test plan
- Reset, zero-wait memory, program `8'h22 8'h05` (LI r0,5): `imem_addr` 0 then 1; `rf_we`=1 with `rf_wsel`=1, `imm`=5, `rf_waddr`=0 in cycle 3; `pc`=2.
- ARITH SUB `8'h71` (rd r0, rs2 r1) with `alu_out`=0, `alu_overflow`=1 driven: `alu_ctrl`=011, `alu_flag`=1, `rf_we`=1 in EXEC only; afterwards `zero_flag`=1, `ovf_flag`=1.
- BZ `8'h40 8'h80` with `zero_flag`=1 → next `imem_addr`=8'h80. Same program with `zero_flag`=0 → next address = branch address + 2.
- Memory with 3 wait cycles: `imem_req` and `imem_addr` held 4 cycles, IR is captured only on `imem_valid`; a `pc`=8'hFF fetch wraps to 8'h00.
- Opcode `8'hA0` → `illegal` pulses 1 cycle, no `rf_we`; then `8'hE0` → `halted`=1 and `imem_req` stays 0 indefinitely.
- Assert `rst_n` low while `imem_req`=1 waiting → outputs return to reset values immediately; refetch from `RESET_PC` after release.
